// File: rtl/hist_cell_scheduler.sv
// hist_cell_scheduler: raster-scans a CELLS_X x CELLS_Y window one histogram cell at a time.
// Optional macro HIST_SCHED_TIMEOUT_EN adds a WAIT watchdog driving the sticky oErr flag.
module hist_cell_scheduler #(
    parameter int CELLS_X = 8,
    parameter int CELLS_Y = 16,
    parameter int TIMEOUT = 200
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iStart,
    input  logic         iAbort,
    input  logic         iHistDone,
    input  logic [287:0] iBins,
    input  logic         iBinReady,
    output logic         oLoad,
    output logic [7:0]   oCellX,
    output logic [7:0]   oCellY,
    output logic [287:0] oBins,
    output logic         oBinValid,
    output logic         oBusy,
    output logic         oFrameDone,
    output logic         oErr
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, OUT, DONE} state_t;

    localparam logic [7:0] X_MAX = 8'(CELLS_X - 1);
    localparam logic [7:0] Y_MAX = 8'(CELLS_Y - 1);

    state_t       state_q, state_d;
    logic [7:0]   x_q, x_d, y_q, y_d;
    logic [287:0] bins_q;
    logic         timeout;

`ifdef HIST_SCHED_TIMEOUT_EN
    logic [31:0] cnt_q;
    logic        err_q;

    assign timeout = (state_q == WAIT) && !iHistDone && (cnt_q == 32'(TIMEOUT - 1));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == WAIT) ? cnt_q + 32'd1 : '0;
            if (state_q == IDLE && iStart)
                err_q <= 1'b0;
            else if (timeout && !iAbort)
                err_q <= 1'b1;
        end
    end

    assign oErr = err_q;
`else
    assign timeout = 1'b0;
    assign oErr    = 1'b0;
`endif

    // Abort wins over every in-flight handshake; any exit to IDLE clears the coordinates.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (state_q != IDLE && iAbort) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                IDLE: if (iStart) begin
                    state_d = LOAD;
                    x_d     = '0;
                    y_d     = '0;
                end
                LOAD: state_d = WAIT;
                WAIT: begin
                    if (iHistDone) begin
                        state_d = OUT;
                    end else if (timeout) begin
                        state_d = IDLE;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
                OUT: if (iBinReady) begin
                    if (x_q != X_MAX) begin
                        x_d     = x_q + 8'd1;
                        state_d = LOAD;
                    end else if (y_q != Y_MAX) begin
                        x_d     = '0;
                        y_d     = y_q + 8'd1;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            bins_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (state_q == WAIT && iHistDone && !iAbort)
                bins_q <= iBins;
        end
    end

    assign oLoad      = (state_q == LOAD);
    assign oBinValid  = (state_q == OUT);
    assign oBusy      = (state_q != IDLE);
    assign oFrameDone = (state_q == DONE);
    assign oCellX     = x_q;
    assign oCellY     = y_q;
    assign oBins      = bins_q;
endmodule

// File: tb/tb_hist_cell_scheduler.sv
// tb_hist_cell_scheduler: directed + randomized scans of a 2x2 window against a raster-order model.
module tb_hist_cell_scheduler;
    localparam int CX = 2;
    localparam int CY = 2;

    logic         iClk = 1'b0;
    logic         iRst_n = 1'b1;
    logic         iStart = 1'b0;
    logic         iAbort = 1'b0;
    logic         iHistDone = 1'b0;
    logic [287:0] iBins = '0;
    logic         iBinReady = 1'b0;
    logic         oLoad;
    logic [7:0]   oCellX;
    logic [7:0]   oCellY;
    logic [287:0] oBins;
    logic         oBinValid;
    logic         oBusy;
    logic         oFrameDone;
    logic         oErr;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [287:0] last_bins = '0;

    hist_cell_scheduler #(.CELLS_X(CX), .CELLS_Y(CY), .TIMEOUT(200)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iAbort(iAbort),
        .iHistDone(iHistDone), .iBins(iBins), .iBinReady(iBinReady),
        .oLoad(oLoad), .oCellX(oCellX), .oCellY(oCellY), .oBins(oBins),
        .oBinValid(oBinValid), .oBusy(oBusy), .oFrameDone(oFrameDone), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [287:0] rand_bins();
        logic [287:0] r;
        for (int k = 0; k < 9; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    // Model: cell i of a window sits at (i mod CX, i div CX); bins must match what was offered at done.
    task automatic run_cell(input int i, input int lat, input int hold, input bit poke);
        logic [287:0] b;
        chk("load", {287'd0, oLoad}, 288'd1);
        chk("cell_x", {280'd0, oCellX}, 288'(i % CX));
        chk("cell_y", {280'd0, oCellY}, 288'(i / CX));
        chk("busy", {287'd0, oBusy}, 288'd1);
        tick();
        chk("load_one_cycle", {287'd0, oLoad}, 288'd0);
        for (int k = 1; k < lat; k++) begin
            if (poke && k == 1) begin
                iStart = 1'b1;
                tick();
                iStart = 1'b0;
                chk("wait_start_x", {280'd0, oCellX}, 288'(i % CX));
                chk("wait_start_load", {287'd0, oLoad}, 288'd0);
                chk("wait_start_valid", {287'd0, oBinValid}, 288'd0);
            end else begin
                tick();
            end
        end
        b = rand_bins();
        iHistDone = 1'b1;
        iBins = b;
        tick();
        iHistDone = 1'b0;
        iBins = rand_bins();
        chk("valid", {287'd0, oBinValid}, 288'd1);
        chk("bins", oBins, b);
        for (int h = 0; h < hold; h++) begin
            iBins = rand_bins();
            tick();
            chk("hold_valid", {287'd0, oBinValid}, 288'd1);
            chk("hold_bins", oBins, b);
            chk("hold_load", {287'd0, oLoad}, 288'd0);
        end
        last_bins = b;
        iBinReady = 1'b1;
        tick();
        iBinReady = 1'b0;
        if (i == CX * CY - 1) begin
            chk("frame_done", {287'd0, oFrameDone}, 288'd1);
            chk("done_valid", {287'd0, oBinValid}, 288'd0);
            tick();
            chk("frame_done_pulse", {287'd0, oFrameDone}, 288'd0);
            chk("idle_busy", {287'd0, oBusy}, 288'd0);
            chk("idle_x", {280'd0, oCellX}, 288'd0);
            chk("idle_y", {280'd0, oCellY}, 288'd0);
        end else begin
            chk("no_frame_done", {287'd0, oFrameDone}, 288'd0);
        end
    endtask

    task automatic run_scan(input bit fixed);
        start();
        for (int i = 0; i < CX * CY; i++)
            run_cell(i, fixed ? 113 : int'($urandom_range(2, 8)),
                     fixed ? (i == 1 ? 10 : 0) : int'($urandom_range(0, 3)), fixed && i == 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_load", {287'd0, oLoad}, 288'd0);
        chk("rst_x", {280'd0, oCellX}, 288'd0);
        chk("rst_y", {280'd0, oCellY}, 288'd0);
        chk("rst_bins", oBins, 288'd0);
        chk("rst_valid", {287'd0, oBinValid}, 288'd0);
        chk("rst_busy", {287'd0, oBusy}, 288'd0);
        chk("rst_frame", {287'd0, oFrameDone}, 288'd0);
        chk("rst_err", {287'd0, oErr}, 288'd0);
    endtask

    initial begin
        #2 iRst_n = 1'b0;
        #2 chk_reset_outputs();
        #8 iRst_n = 1'b1;
        tick();
        chk("idle_after_rst", {287'd0, oBusy}, 288'd0);

        run_scan(1'b1);

        iHistDone = 1'b1;
        iBins = rand_bins();
        tick();
        iHistDone = 1'b0;
        chk("idle_done_busy", {287'd0, oBusy}, 288'd0);
        chk("idle_done_valid", {287'd0, oBinValid}, 288'd0);
        chk("idle_done_bins", oBins, last_bins);

        repeat (3) run_scan(1'b0);

        start();
        run_cell(0, 3, 1, 1'b0);
        chk("abort_load", {287'd0, oLoad}, 288'd1);
        chk("abort_x", {280'd0, oCellX}, 288'd1);
        repeat (4) tick();
        iHistDone = 1'b1;
        iAbort = 1'b1;
        iBins = rand_bins();
        iBinReady = 1'b1;
        tick();
        iHistDone = 1'b0;
        iAbort = 1'b0;
        iBinReady = 1'b0;
        chk("abort_busy", {287'd0, oBusy}, 288'd0);
        chk("abort_valid", {287'd0, oBinValid}, 288'd0);
        chk("abort_frame", {287'd0, oFrameDone}, 288'd0);
        chk("abort_x0", {280'd0, oCellX}, 288'd0);
        chk("abort_bins", oBins, last_bins);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_frame", {287'd0, oFrameDone}, 288'd0);
        end
        run_scan(1'b0);

`ifdef HIST_SCHED_TIMEOUT_EN
        start();
        tick();
        repeat (199) tick();
        chk("to_err_early", {287'd0, oErr}, 288'd0);
        chk("to_busy_early", {287'd0, oBusy}, 288'd1);
        tick();
        chk("to_err", {287'd0, oErr}, 288'd1);
        chk("to_idle", {287'd0, oBusy}, 288'd0);
        chk("to_frame", {287'd0, oFrameDone}, 288'd0);
        start();
        chk("to_err_clear", {287'd0, oErr}, 288'd0);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
`else
        start();
        tick();
        repeat (250) tick();
        chk("wait_busy", {287'd0, oBusy}, 288'd1);
        chk("wait_err", {287'd0, oErr}, 288'd0);
        chk("wait_valid", {287'd0, oBinValid}, 288'd0);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        chk("wait_abort", {287'd0, oBusy}, 288'd0);
`endif

        start();
        tick();
        #2 iRst_n = 1'b0;
        #1 chk_reset_outputs();
        #3 iRst_n = 1'b1;
        tick();
        chk("post_rst_idle", {287'd0, oBusy}, 288'd0);
        run_scan(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
